weight_fetch_unit: RTL and testbench
====================================

# weight_fetch_unit

Parametrised weight fetch unit: the successor to the fixed 64-channel weight bus interface. On `start` it fetches the 3x3 and/or 1x1 kernel weights for one output channel from external memory through the arbiter's request/response ports. Input-channel count is runtime-configurable, up to `MAX_OUTSTANDING` read requests can be in flight, and returned words are written to the MAC-array weight buffer with a structured write address. It sits between the layer controller (start/done) and the memory arbiter.

## Interface
Parameters:
- `ADDR_W`, 32, byte-address width of arbiter requests.
- `DATA_W`, 32, data word width; `LANES = DATA_W/8` int8 weights per word.
- `CH_W`, 8, width of channel-count and channel-index fields.
- `MAX_OUTSTANDING`, 4, maximum accepted-but-unanswered requests (≥1).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; sampled only in IDLE.
- `cfg_mode`  in  2  bit0 fetches the 3x3 kernel; bit1 fetches the 1x1 kernel.
- `cfg_in_ch`  in  CH_W  input channels (1..2^CH_W-1).
- `cfg_och`  in  CH_W  output-channel index.
- `cfg_w3_base`, `cfg_w1_base`  in  ADDR_W  kernel base addresses.
- `busy`  out  1  high from the accepted start until the done cycle, inclusive.
- `done`  out  1  one-cycle pulse after the last response is written.
- `req_addr`  out  ADDR_W  request byte address.
- `req_vld`  out  1  request valid.
- `req_rdy`  in  1  arbiter accepts the request.
- `rsp_data`  in  DATA_W  response data (in request order).
- `rsp_vld`  in  1  response valid.
- `rsp_rdy`  out  1  constant 1.
- `wb_wen`  out  1  weight-buffer write enable, equal to `rsp_vld`.
- `wb_waddr`  out  1+4+WIDX_W  {kind (0=3x3, 1=1x1), kernel position 0..8, word index}.
- `wb_och`  out  CH_W  latched `cfg_och`.
- `wb_wdata`  out  DATA_W  equal to `rsp_data`.

## Operation
- On an accepted start, latch all `cfg_*`. Compute `words = ceil(in_ch/LANES)`, `n3 = 9*words` and `n1 = words`.
- Request FSM states: IDLE, REQ3, REQ1, DRAIN.
  - IDLE with start: go to REQ3 if `mode[0]`, else REQ1 if `mode[1]`, else DRAIN.
  - REQ3 after n3 accepted requests: go to REQ1 if `mode[1]`, else DRAIN.
  - REQ1 after n1 accepted requests: go to DRAIN.
  - DRAIN when the outstanding count is 0 and all responses are received: pulse `done`, go to IDLE.
- Addresses:
  - REQ3 starts at `w3_base + och*n3*(DATA_W/8)`.
  - REQ1 starts at `w1_base + och*n1*(DATA_W/8)`.
  - Each accepted request adds `DATA_W/8`. All arithmetic is modulo 2^ADDR_W.
- `outstanding` counter:
  - +1 on a request handshake, −1 on a response.
  - Simultaneous request and response: no change.
  - `req_vld` is 0 when `outstanding == MAX_OUTSTANDING`.
- Receive side runs independently with its own counters: kind, position and word. The word index wraps at `words`, then the position increments. When the 3x3 position wraps past 8, kind switches to 1x1.
- `start` while busy is ignored. `mode == 0` produces no requests; `done` pulses 2 cycles after start.
- A response arriving while not busy is an error. It is written anyway and flagged by a bench assertion.

## Timing
- Reset values: `busy`=0, `done`=0, `req_vld`=0, `req_addr`=0; all counters and the FSM at 0/IDLE; `rsp_rdy`=1.
- `req_vld` and `req_addr` are registered. The first request appears 1 cycle after start.
- While `req_vld`=1 and `req_rdy`=0, `req_addr` is held stable. `req_vld` never drops without a handshake, except at the outstanding limit, where it is never raised.
- Back-to-back requests: one per cycle when `req_rdy`=1 and credit is available.
- Write path is combinational: `wb_wen` = `rsp_vld` in the same cycle.
- `done` is registered, 1 cycle after the final response. `busy` falls in the cycle after `done`.
- `rst` asserted mid-fetch: all state clears immediately. Late responses after reset are not tracked.

## Structure
- Shared package `acc_pkg`: FSM state enum, kind encodings (`KIND_3X3`=0, `KIND_1X1`=1), `KPOS_3X3`=9, `clog2`-based `WIDX_W = clog2(2^CH_W/LANES)`.
- One natural sub-module `wfu_rsp_track`: receive counters and `wb_waddr` generation.

## Test plan
- mode=3, in_ch=64, och=2, DATA_W=32, `req_rdy`=1, 1-cycle response latency:
  - Exactly 160 requests.
  - First address = w3_base+0x480.
  - Request 145 address = w1_base+0x80.
  - `done` 1 cycle after the 160th response.
- in_ch=5, mode=1 → words=2, 18 requests, `wb_waddr` word index toggles 0/1, kernel position 0..8.
- Response latency 20 cycles, MAX_OUTSTANDING=4 → `outstanding` never exceeds 4, `req_vld` low while at limit, no lost or duplicate writes.
- Random `req_rdy` stalls → `req_addr` stable during each stall, address sequence identical to the no-stall run.
- mode=0 → no `req_vld`, `done` at start+2. `start` during busy → ignored, single `done`.
- `rst` asserted at request 50 → all outputs return to reset values asynchronously. A new start after release fetches correctly from request 0.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared definitions for the accelerator weight-fetch path.
//   wfu_state_e : request-side FSM states
//   KIND_*      : weight-buffer kind field encodings
//   KPOS_3X3    : kernel positions in a 3x3 kernel
//   clog2 / widx_width : width helpers usable in parameter expressions
package acc_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StReq3  = 2'd1,
    StReq1  = 2'd2,
    StDrain = 2'd3
  } wfu_state_e;

  localparam logic KIND_3X3 = 1'b0;
  localparam logic KIND_1X1 = 1'b1;

  localparam int unsigned KPOS_3X3 = 9;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Word-index width; never zero so the address field always exists.
  function automatic int unsigned widx_width(input int unsigned ch_w, input int unsigned lanes);
    int unsigned w;
    w = clog2((32'd1 << ch_w) / lanes);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/wfu_rsp_track.sv
// Receive-side tracker for the weight fetch unit. Counts returned words
// independently of the request side and forms the weight-buffer address
// {kind, kernel position, word index}.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   clear       : accepted start; reloads the counters
//   init_kind   : kind of the first response of the new fetch
//   words       : words per kernel position (1..2^WIDX_W)
//   rsp_vld     : a response word is being written this cycle
//   waddr       : weight-buffer write address for the current response
module wfu_rsp_track
  import acc_pkg::*;
#(
  parameter int unsigned WIDX_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              init_kind,
  input  logic [WIDX_W:0]   words,
  input  logic              rsp_vld,
  output logic [WIDX_W+4:0] waddr
);

  localparam int unsigned WORDS_W  = WIDX_W + 1;
  localparam logic [3:0]  POS_LAST = 4'(KPOS_3X3 - 1);

  logic              kind_q, kind_d;
  logic [3:0]        pos_q, pos_d;
  logic [WIDX_W-1:0] widx_q, widx_d;
  logic              word_last;

  assign word_last = (WORDS_W'(widx_q) + WORDS_W'(1)) == words;

  always_comb begin
    kind_d = kind_q;
    pos_d  = pos_q;
    widx_d = widx_q;
    if (clear) begin
      kind_d = init_kind;
      pos_d  = '0;
      widx_d = '0;
    end else if (rsp_vld) begin
      if (word_last) begin
        widx_d = '0;
        // 1x1 has a single position; only 3x3 walks positions 0..8.
        if (kind_q == KIND_3X3) begin
          if (pos_q == POS_LAST) begin
            pos_d  = '0;
            kind_d = KIND_1X1;
          end else begin
            pos_d = pos_q + 4'd1;
          end
        end
      end else begin
        widx_d = widx_q + WIDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kind_q <= KIND_3X3;
      pos_q  <= '0;
      widx_q <= '0;
    end else begin
      kind_q <= kind_d;
      pos_q  <= pos_d;
      widx_q <= widx_d;
    end
  end

  assign waddr = {kind_q, pos_q, widx_q};

endmodule

// File: rtl/weight_fetch_unit.sv
// Weight fetch unit: on start, reads the 3x3 and/or 1x1 kernel weights of one
// output channel through the arbiter request/response ports and writes each
// returned word into the MAC-array weight buffer.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   start, cfg_*             : fetch command from the layer controller
//   busy, done               : status back to the layer controller
//   req_addr/req_vld/req_rdy : read requests to the arbiter (registered)
//   rsp_data/rsp_vld/rsp_rdy : in-order read responses (rsp_rdy tied high)
//   wb_*                     : weight-buffer write port (combinational)
module weight_fetch_unit
  import acc_pkg::*;
#(
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned CH_W            = 8,
  parameter int unsigned MAX_OUTSTANDING = 4,
  localparam int unsigned LANES          = DATA_W / 8,
  localparam int unsigned WIDX_W         = widx_width(CH_W, LANES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        cfg_mode,
  input  logic [CH_W-1:0]   cfg_in_ch,
  input  logic [CH_W-1:0]   cfg_och,
  input  logic [ADDR_W-1:0] cfg_w3_base,
  input  logic [ADDR_W-1:0] cfg_w1_base,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] req_addr,
  output logic              req_vld,
  input  logic              req_rdy,
  input  logic [DATA_W-1:0] rsp_data,
  input  logic              rsp_vld,
  output logic              rsp_rdy,
  output logic              wb_wen,
  output logic [WIDX_W+4:0] wb_waddr,
  output logic [CH_W-1:0]   wb_och,
  output logic [DATA_W-1:0] wb_wdata
);

  localparam int unsigned BYTES   = DATA_W / 8;
  localparam int unsigned WORDS_W = WIDX_W + 1;
  // Holds 9 * words with margin.
  localparam int unsigned CNT_W   = WIDX_W + 5;
  localparam int unsigned OUT_W   = clog2(MAX_OUTSTANDING + 1);

  wfu_state_e state_q, state_d;

  logic [1:0]         mode_q;
  logic [CH_W-1:0]    och_q;
  logic [WORDS_W-1:0] words_q;
  logic [CNT_W-1:0]   n3_q, n1_q;
  logic [ADDR_W-1:0]  addr1_q;

  logic [CNT_W-1:0]   req_cnt_q, req_cnt_d;
  logic [ADDR_W-1:0]  req_addr_q, req_addr_d;
  logic               req_vld_q, req_vld_d;
  logic               done_q, done_d;
  logic [OUT_W-1:0]   out_q, out_d;

  logic               accept;
  logic               req_hs;
  logic               rsp_dec;
  logic               room;

  logic [WORDS_W-1:0] words_calc;
  logic [CNT_W-1:0]   n3_calc, n1_calc;
  logic [ADDR_W-1:0]  addr3_calc, addr1_calc;

  // The done cycle still counts as busy, so a start there is ignored too.
  assign accept  = start && (state_q == StIdle) && !done_q;
  assign req_hs  = req_vld_q & req_rdy;
  // Stray responses while idle must not wrap the credit counter.
  assign rsp_dec = rsp_vld & (out_q != '0);

  // Start-time geometry from the live configuration inputs.
  always_comb begin
    words_calc = WORDS_W'((32'(cfg_in_ch) + LANES - 1) / LANES);
    n3_calc    = CNT_W'(KPOS_3X3) * CNT_W'(words_calc);
    n1_calc    = CNT_W'(words_calc);
    addr3_calc = cfg_w3_base + ADDR_W'(cfg_och) * ADDR_W'(n3_calc) * ADDR_W'(BYTES);
    addr1_calc = cfg_w1_base + ADDR_W'(cfg_och) * ADDR_W'(n1_calc) * ADDR_W'(BYTES);
  end

  always_comb begin
    out_d = out_q;
    case ({req_hs, rsp_dec})
      2'b10:   out_d = out_q + OUT_W'(1);
      2'b01:   out_d = out_q - OUT_W'(1);
      default: out_d = out_q;
    endcase
  end

  // req_vld is registered from next-cycle credit, so it is never raised at
  // the limit and, having been raised, stays up until its handshake.
  assign room = out_d < OUT_W'(MAX_OUTSTANDING);

  always_comb begin
    state_d    = state_q;
    req_cnt_d  = req_cnt_q;
    req_addr_d = req_addr_q;
    req_vld_d  = 1'b0;
    done_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          req_cnt_d = '0;
          if (cfg_mode[0]) begin
            state_d    = StReq3;
            req_addr_d = addr3_calc;
            req_vld_d  = room;
          end else if (cfg_mode[1]) begin
            state_d    = StReq1;
            req_addr_d = addr1_calc;
            req_vld_d  = room;
          end else begin
            state_d = StDrain;
          end
        end
      end
      StReq3: begin
        req_vld_d = room;
        if (req_hs) begin
          req_addr_d = req_addr_q + ADDR_W'(BYTES);
          req_cnt_d  = req_cnt_q + CNT_W'(1);
          if (req_cnt_q == n3_q - CNT_W'(1)) begin
            req_cnt_d = '0;
            if (mode_q[1]) begin
              state_d    = StReq1;
              req_addr_d = addr1_q;
            end else begin
              state_d   = StDrain;
              req_vld_d = 1'b0;
            end
          end
        end
      end
      StReq1: begin
        req_vld_d = room;
        if (req_hs) begin
          req_addr_d = req_addr_q + ADDR_W'(BYTES);
          req_cnt_d  = req_cnt_q + CNT_W'(1);
          if (req_cnt_q == n1_q - CNT_W'(1)) begin
            req_cnt_d = '0;
            state_d   = StDrain;
            req_vld_d = 1'b0;
          end
        end
      end
      StDrain: begin
        // Every request has been accepted here, so zero credit in use means
        // the final response is being written this cycle (or already was).
        if (out_d == '0) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      req_cnt_q  <= '0;
      req_addr_q <= '0;
      req_vld_q  <= 1'b0;
      done_q     <= 1'b0;
      out_q      <= '0;
      mode_q     <= '0;
      och_q      <= '0;
      words_q    <= '0;
      n3_q       <= '0;
      n1_q       <= '0;
      addr1_q    <= '0;
    end else begin
      state_q    <= state_d;
      req_cnt_q  <= req_cnt_d;
      req_addr_q <= req_addr_d;
      req_vld_q  <= req_vld_d;
      done_q     <= done_d;
      out_q      <= out_d;
      if (accept) begin
        mode_q  <= cfg_mode;
        och_q   <= cfg_och;
        words_q <= words_calc;
        n3_q    <= n3_calc;
        n1_q    <= n1_calc;
        addr1_q <= addr1_calc;
      end
    end
  end

  wfu_rsp_track #(
    .WIDX_W (WIDX_W)
  ) u_rsp_track (
    .clk       (clk),
    .rst       (rst),
    .clear     (accept),
    .init_kind (cfg_mode[0] ? KIND_3X3 : KIND_1X1),
    .words     (words_q),
    .rsp_vld   (rsp_vld),
    .waddr     (wb_waddr)
  );

  assign busy     = (state_q != StIdle) | done_q;
  assign done     = done_q;
  assign req_addr = req_addr_q;
  assign req_vld  = req_vld_q;
  assign rsp_rdy  = 1'b1;
  assign wb_wen   = rsp_vld;
  assign wb_wdata = rsp_data;
  assign wb_och   = och_q;

endmodule

// File: tb/tb_weight_fetch_unit.sv
module tb_weight_fetch_unit;

  localparam int MAXO = 4;
  localparam logic [31:0] B3 = 32'h1000_0000;
  localparam logic [31:0] B1 = 32'h2000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  cfg_mode;
  logic [7:0]  cfg_in_ch, cfg_och;
  logic [31:0] cfg_w3_base, cfg_w1_base;
  logic        busy, done, req_vld, req_rdy, rsp_vld, rsp_rdy, wb_wen;
  logic [31:0] req_addr, rsp_data, wb_wdata;
  logic [10:0] wb_waddr;
  logic [7:0]  wb_och;

  weight_fetch_unit #(
    .ADDR_W          (32),
    .DATA_W          (32),
    .CH_W            (8),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .cfg_mode    (cfg_mode),
    .cfg_in_ch   (cfg_in_ch),
    .cfg_och     (cfg_och),
    .cfg_w3_base (cfg_w3_base),
    .cfg_w1_base (cfg_w1_base),
    .busy        (busy),
    .done        (done),
    .req_addr    (req_addr),
    .req_vld     (req_vld),
    .req_rdy     (req_rdy),
    .rsp_data    (rsp_data),
    .rsp_vld     (rsp_vld),
    .rsp_rdy     (rsp_rdy),
    .wb_wen      (wb_wen),
    .wb_waddr    (wb_waddr),
    .wb_och      (wb_och),
    .wb_wdata    (wb_wdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passed = 0;

  int lat = 1;
  bit stall_en = 1'b0;

  logic [31:0] req_log[$];
  logic [10:0] wa_log[$];
  int          pend_due[$];
  logic [31:0] pend_dat[$];

  int out_model = 0, out_max = 0, limit_viol = 0, stall_viol = 0, stall_seen = 0;
  int wr_viol = 0, stray = 0;
  int done_cnt = 0, done_cyc = -1, last_rsp_cyc = -1, first_req_cyc = -1, vld_cnt = 0;
  bit busy_at_done = 1'b0;
  bit prev_stall = 1'b0;
  bit hs;
  logic [31:0] prev_addr = '0;

  // Arbiter/memory model: accepts requests, returns data after `lat` cycles
  // in order, and monitors the request and write-port rules.
  always @(negedge clk) begin
    if (rst) begin
      pend_due.delete();
      pend_dat.delete();
      out_model  = 0;
      prev_stall = 1'b0;
      req_rdy    = 1'b0;
      rsp_vld    = 1'b0;
      rsp_data   = '0;
    end else begin
      if (done) begin
        done_cnt++;
        done_cyc     = cyc;
        busy_at_done = busy;
      end
      if (req_vld) begin
        vld_cnt++;
        if (first_req_cyc < 0) first_req_cyc = cyc;
      end
      if (prev_stall && (req_vld !== 1'b1 || req_addr !== prev_addr)) stall_viol++;
      if (req_vld && out_model >= MAXO) limit_viol++;
      req_rdy = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (req_vld && !req_rdy) stall_seen++;
      prev_stall = req_vld & ~req_rdy;
      prev_addr  = req_addr;
      hs = req_vld && req_rdy;
      if (hs) begin
        req_log.push_back(req_addr);
        pend_due.push_back(cyc + lat);
        pend_dat.push_back(req_addr ^ 32'hC3C3_5A5A);
      end
      if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
        rsp_vld  = 1'b1;
        rsp_data = pend_dat.pop_front();
        void'(pend_due.pop_front());
        last_rsp_cyc = cyc;
      end else begin
        rsp_vld = 1'b0;
      end
      out_model = out_model + (hs ? 1 : 0) - (rsp_vld ? 1 : 0);
      if (out_model > out_max) out_max = out_model;
      #1;
      if (wb_wen !== rsp_vld) wr_viol++;
      if (rsp_vld) begin
        if (wb_wdata !== rsp_data) wr_viol++;
        if (!busy) stray++;
        wa_log.push_back(wb_waddr);
      end
    end
  end

  function automatic logic [31:0] exp_addr(input int i, input logic [1:0] m, input int inch,
                                           input int och);
    int w;
    int n3;
    w  = (inch + 3) / 4;
    n3 = 9 * w;
    if (m[0] && i < n3) return B3 + 32'(och * n3 * 4) + 32'(i * 4);
    return B1 + 32'(och * w * 4) + 32'((m[0] ? i - n3 : i) * 4);
  endfunction

  function automatic logic [10:0] exp_wa(input int i, input logic [1:0] m, input int inch);
    int w;
    int n3;
    w  = (inch + 3) / 4;
    n3 = 9 * w;
    if (m[0] && i < n3) return {1'b0, 4'(i / w), 6'(i % w)};
    return {1'b1, 4'd0, 6'(m[0] ? i - n3 : i)};
  endfunction

  task automatic clear_logs();
    req_log.delete();
    wa_log.delete();
    out_max = 0; limit_viol = 0; stall_viol = 0; stall_seen = 0; wr_viol = 0;
    done_cnt = 0; done_cyc = -1; last_rsp_cyc = -1; first_req_cyc = -1; vld_cnt = 0;
  endtask

  task automatic do_start(input logic [1:0] m, input int inch, input int och, output int scyc);
    @(negedge clk);
    cfg_mode  = m;
    cfg_in_ch = 8'(inch);
    cfg_och   = 8'(och);
    start     = 1'b1;
    scyc      = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k;
    k = 0;
    while (done_cnt == 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (done_cnt == 0) $display("FAIL %s: done not seen within %0d cycles", name, budget);
    else passed++;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
    checks++; if (req_vld !== 1'b0) $display("FAIL reset_req_vld: got %b want 0", req_vld);
    else passed++;
    checks++; if (req_addr !== 32'h0) $display("FAIL reset_req_addr: got %h want 0", req_addr);
    else passed++;
    checks++; if (rsp_rdy !== 1'b1) $display("FAIL reset_rsp_rdy: got %b want 1", rsp_rdy);
    else passed++;
    checks++; if (wb_waddr !== 11'h0) $display("FAIL reset_waddr: got %h want 0", wb_waddr);
    else passed++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_full();
    int s;
    int bad;
    clear_logs();
    lat = 1;
    stall_en = 1'b0;
    do_start(2'b11, 64, 2, s);
    wait_done("full_done", 1000);
    checks++; if (req_log.size() != 160)
      $display("FAIL full_count: got %0d requests want 160", req_log.size()); else passed++;
    checks++; if (req_log[0] !== 32'h1000_0480)
      $display("FAIL full_first_addr: got %h want 10000480", req_log[0]); else passed++;
    checks++; if (req_log[144] !== 32'h2000_0080)
      $display("FAIL full_req145_addr: got %h want 20000080", req_log[144]); else passed++;
    checks++; if (req_log[159] !== 32'h2000_00BC)
      $display("FAIL full_last_addr: got %h want 200000bc", req_log[159]); else passed++;
    bad = 0;
    for (int i = 0; i < req_log.size(); i++) if (req_log[i] !== exp_addr(i, 2'b11, 64, 2)) bad++;
    checks++; if (bad != 0) $display("FAIL full_addr_seq: %0d wrong want 0", bad); else passed++;
    checks++; if (first_req_cyc != s + 1)
      $display("FAIL full_first_req_cyc: got %0d want %0d", first_req_cyc, s + 1); else passed++;
    checks++; if (done_cyc != last_rsp_cyc + 1)
      $display("FAIL full_done_timing: got %0d want %0d", done_cyc, last_rsp_cyc + 1);
    else passed++;
    checks++; if (done_cnt != 1) $display("FAIL full_done_count: got %0d want 1", done_cnt);
    else passed++;
    checks++; if (wa_log[16] !== 11'h040)
      $display("FAIL full_wa16: got %h want 040", wa_log[16]); else passed++;
    checks++; if (wa_log[144] !== 11'h400)
      $display("FAIL full_wa144: got %h want 400", wa_log[144]); else passed++;
    checks++; if (wa_log[159] !== 11'h40F)
      $display("FAIL full_wa159: got %h want 40f", wa_log[159]); else passed++;
    checks++; if (wr_viol != 0) $display("FAIL full_write_port: %0d errors want 0", wr_viol);
    else passed++;
    checks++; if (wb_och !== 8'd2) $display("FAIL full_wb_och: got %0d want 2", wb_och);
    else passed++;
    checks++; if (busy_at_done !== 1'b1) $display("FAIL full_busy_at_done: got 0 want 1");
    else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL full_busy_after: got %b want 0", busy);
    else passed++;
  endtask

  task automatic test_small();
    int s;
    int bad;
    clear_logs();
    do_start(2'b01, 5, 3, s);
    wait_done("small_done", 500);
    checks++; if (req_log.size() != 18)
      $display("FAIL small_count: got %0d want 18", req_log.size()); else passed++;
    checks++; if (req_log[0] !== 32'h1000_00D8)
      $display("FAIL small_first_addr: got %h want 100000d8", req_log[0]); else passed++;
    checks++; if (wa_log[1] !== 11'h001)
      $display("FAIL small_wa1: got %h want 001", wa_log[1]); else passed++;
    checks++; if (wa_log[2] !== 11'h040)
      $display("FAIL small_wa2: got %h want 040", wa_log[2]); else passed++;
    checks++; if (wa_log[17] !== 11'h201)
      $display("FAIL small_wa17: got %h want 201", wa_log[17]); else passed++;
    bad = (wa_log.size() == 18) ? 0 : 1;
    for (int i = 0; i < wa_log.size(); i++) if (wa_log[i] !== exp_wa(i, 2'b01, 5)) bad++;
    checks++; if (bad != 0) $display("FAIL small_wa_seq: %0d wrong want 0", bad); else passed++;
  endtask

  task automatic test_backpressure();
    int s;
    int bad;
    clear_logs();
    lat = 20;
    do_start(2'b11, 16, 0, s);
    wait_done("bp_done", 3000);
    checks++; if (req_log.size() != 40)
      $display("FAIL bp_count: got %0d want 40", req_log.size()); else passed++;
    checks++; if (out_max != MAXO)
      $display("FAIL bp_max_outstanding: got %0d want %0d", out_max, MAXO); else passed++;
    checks++; if (limit_viol != 0)
      $display("FAIL bp_vld_at_limit: got %0d cycles want 0", limit_viol); else passed++;
    bad = (wa_log.size() == 40) ? 0 : 1;
    for (int i = 0; i < wa_log.size(); i++) if (wa_log[i] !== exp_wa(i, 2'b11, 16)) bad++;
    checks++; if (bad != 0) $display("FAIL bp_writes: %0d wrong want 0", bad); else passed++;
    checks++; if (wr_viol != 0) $display("FAIL bp_write_port: %0d errors want 0", wr_viol);
    else passed++;
    lat = 1;
  endtask

  task automatic test_stall();
    int s;
    int bad;
    clear_logs();
    lat = 2;
    stall_en = 1'b1;
    do_start(2'b11, 8, 1, s);
    wait_done("stall_done", 1000);
    stall_en = 1'b0;
    checks++; if (req_log.size() != 20)
      $display("FAIL stall_count: got %0d want 20", req_log.size()); else passed++;
    checks++; if (stall_seen == 0) $display("FAIL stall_seen: got 0 stalls want >0");
    else passed++;
    checks++; if (stall_viol != 0)
      $display("FAIL stall_hold: got %0d unstable stalls want 0", stall_viol); else passed++;
    bad = 0;
    for (int i = 0; i < req_log.size(); i++) if (req_log[i] !== exp_addr(i, 2'b11, 8, 1)) bad++;
    checks++; if (bad != 0) $display("FAIL stall_addr_seq: %0d wrong want 0", bad); else passed++;
    lat = 1;
  endtask

  task automatic test_mode0_busy();
    int s;
    int s2;
    clear_logs();
    do_start(2'b00, 16, 1, s);
    wait_done("mode0_done", 50);
    checks++; if (vld_cnt != 0) $display("FAIL mode0_no_req: got %0d want 0", vld_cnt);
    else passed++;
    checks++; if (done_cyc != s + 2)
      $display("FAIL mode0_done_cyc: got %0d want %0d", done_cyc, s + 2); else passed++;
    clear_logs();
    do_start(2'b01, 4, 5, s);
    repeat (3) @(negedge clk);
    do_start(2'b11, 64, 7, s2);
    wait_done("busy_done", 500);
    repeat (30) @(negedge clk);
    checks++; if (done_cnt != 1) $display("FAIL busy_single_done: got %0d want 1", done_cnt);
    else passed++;
    checks++; if (req_log.size() != 9)
      $display("FAIL busy_count: got %0d want 9", req_log.size()); else passed++;
    checks++; if (req_log[0] !== 32'h1000_00B4)
      $display("FAIL busy_first_addr: got %h want 100000b4", req_log[0]); else passed++;
    checks++; if (wb_och !== 8'd5) $display("FAIL busy_wb_och: got %0d want 5", wb_och);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int s;
    int k;
    int bad;
    clear_logs();
    do_start(2'b11, 64, 2, s);
    k = 0;
    while (req_log.size() < 50 && k < 500) begin
      @(negedge clk);
      k++;
    end
    checks++; if (req_log.size() < 50)
      $display("FAIL rstmid_reach50: got %0d requests want 50", req_log.size()); else passed++;
    #2 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy); else passed++;
    checks++; if (req_vld !== 1'b0) $display("FAIL rstmid_req_vld: got %b want 0", req_vld);
    else passed++;
    checks++; if (req_addr !== 32'h0) $display("FAIL rstmid_req_addr: got %h want 0", req_addr);
    else passed++;
    checks++; if (wb_waddr !== 11'h0) $display("FAIL rstmid_waddr: got %h want 0", wb_waddr);
    else passed++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_logs();
    do_start(2'b10, 12, 4, s);
    wait_done("rstmid_done", 200);
    checks++; if (req_log.size() != 3)
      $display("FAIL rstmid_count: got %0d want 3", req_log.size()); else passed++;
    checks++; if (req_log[0] !== 32'h2000_0030)
      $display("FAIL rstmid_first_addr: got %h want 20000030", req_log[0]); else passed++;
    bad = (wa_log.size() == 3) ? 0 : 1;
    for (int i = 0; i < wa_log.size(); i++) if (wa_log[i] !== exp_wa(i, 2'b10, 12)) bad++;
    checks++; if (bad != 0) $display("FAIL rstmid_writes: %0d wrong want 0", bad); else passed++;
    checks++; if (stray != 0) $display("FAIL stray_responses: got %0d want 0", stray);
    else passed++;
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    cfg_mode    = 2'b00;
    cfg_in_ch   = 8'd1;
    cfg_och     = 8'd0;
    cfg_w3_base = B3;
    cfg_w1_base = B1;
    req_rdy     = 1'b0;
    rsp_vld     = 1'b0;
    rsp_data    = '0;
    test_reset();
    test_full();
    test_small();
    test_backpressure();
    test_stall();
    test_mode0_busy();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
